// File: rtl/alu_issue_if.sv
// Fetch, regfile and ALU signals of the alu_issue stage.
// slave: the issue stage itself. master: its surroundings (fetch, regfile, ALU).
interface alu_issue_if;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [4:0]  rf_rs1_addr;
  logic [4:0]  rf_rs2_addr;
  logic [31:0] rf_rs1_data;
  logic [31:0] rf_rs2_data;
  logic        alu_valid;
  logic        alu_ready;
  logic [31:0] alu_rs1;
  logic [31:0] alu_rs2;
  logic [6:0]  alu_opcode;
  logic [2:0]  alu_func3;
  logic [6:0]  alu_func7;
  logic [4:0]  alu_rd;
  logic        illegal;

  modport slave (
    input  instr_valid, instr, pc, rf_rs1_data, rf_rs2_data, alu_ready,
    output instr_ready, rf_rs1_addr, rf_rs2_addr, alu_valid, alu_rs1, alu_rs2,
           alu_opcode, alu_func3, alu_func7, alu_rd, illegal
  );

  modport master (
    output instr_valid, instr, pc, rf_rs1_data, rf_rs2_data, alu_ready,
    input  instr_ready, rf_rs1_addr, rf_rs2_addr, alu_valid, alu_rs1, alu_rs2,
           alu_opcode, alu_func3, alu_func7, alu_rd, illegal
  );
endinterface

// File: rtl/alu_issue.sv
// alu_issue: RV32I decode-and-issue stage for OP, OP_IMM and AUIPC.
// Accepts an instruction in IDLE, reads both sources in READ, holds ALU operands in HOLD.
// Optional macro ALU_ISSUE_ILLEGAL_EN: reject unsupported encodings with an `illegal` pulse.
module alu_issue (
  input  logic       clk,
  input  logic       reset,
  alu_issue_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StRead, StHold} state_e;

  localparam logic [6:0] OpcOp    = 7'b0110011;
  localparam logic [6:0] OpcOpImm = 7'b0010011;
  localparam logic [6:0] OpcAuipc = 7'b0010111;
  localparam logic [6:0] F7Alt    = 7'b0100000;

  state_e      state_q, state_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] alu_rs1_q, alu_rs1_d;
  logic [31:0] alu_rs2_q, alu_rs2_d;
  logic [6:0]  alu_opcode_q, alu_opcode_d;
  logic [2:0]  alu_func3_q, alu_func3_d;
  logic [6:0]  alu_func7_q, alu_func7_d;
  logic [4:0]  alu_rd_q, alu_rd_d;
  logic        illegal_q, illegal_d;

  // Decoded fields of the latched instruction.
  logic [6:0]  opcode;
  logic [2:0]  func3;
  logic [6:0]  func7;
  logic [4:0]  rs1_idx;
  logic [4:0]  rs2_idx;

  assign opcode  = instr_q[6:0];
  assign func3   = instr_q[14:12];
  assign func7   = instr_q[31:25];
  assign rs1_idx = instr_q[19:15];
  assign rs2_idx = instr_q[24:20];

  // Source values with x0 forced to zero.
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;

  assign rs1_val = (rs1_idx == 5'd0) ? 32'd0 : bus.rf_rs1_data;
  assign rs2_val = (rs2_idx == 5'd0) ? 32'd0 : bus.rf_rs2_data;

  // Operands that READ will register.
  logic [31:0] op_rs1;
  logic [31:0] op_rs2;
  logic [2:0]  op_func3;
  logic [6:0]  op_func7;

  // Operand build from opcode class.
  always_comb begin
    op_rs1   = rs1_val;
    op_rs2   = rs2_val;
    op_func3 = func3;
    op_func7 = func7;
    case (opcode)
      OpcOp: begin
        op_rs2   = rs2_val;
        op_func7 = func7;
      end
      OpcOpImm: begin
        if (func3 == 3'b001 || func3 == 3'b101) begin
          // Shifts: shamt in rs2 field, func7 selects logical/arithmetic.
          op_rs2   = {27'd0, instr_q[24:20]};
          op_func7 = func7;
        end else begin
          op_rs2   = {{20{instr_q[31]}}, instr_q[31:20]};
          op_func7 = 7'd0;
        end
      end
      OpcAuipc: begin
        op_rs1   = pc_q;
        op_rs2   = {instr_q[31:12], 12'd0};
        op_func3 = 3'd0;
        op_func7 = 7'd0;
      end
      default: begin
        // Unsupported opcodes pass through like OP; the ALU yields 0 for them.
        op_rs2   = rs2_val;
        op_func7 = func7;
      end
    endcase
  end

  logic is_illegal;

`ifdef ALU_ISSUE_ILLEGAL_EN
  // Legality of the latched instruction.
  always_comb begin
    is_illegal = 1'b0;
    case (opcode)
      OpcOp: begin
        if (func7 != 7'd0 && func7 != F7Alt) begin
          is_illegal = 1'b1;
        end else if (func7 == F7Alt && func3 != 3'b000 && func3 != 3'b101) begin
          is_illegal = 1'b1;
        end
      end
      OpcOpImm: begin
        if (func3 == 3'b001 && func7 != 7'd0) begin
          is_illegal = 1'b1;
        end else if (func3 == 3'b101 && func7 != 7'd0 && func7 != F7Alt) begin
          is_illegal = 1'b1;
        end
      end
      OpcAuipc: is_illegal = 1'b0;
      default:  is_illegal = 1'b1;
    endcase
  end
`else
  assign is_illegal = 1'b0;
`endif

  // Next-state and datapath load control.
  always_comb begin
    state_d      = state_q;
    instr_d      = instr_q;
    pc_d         = pc_q;
    alu_rs1_d    = alu_rs1_q;
    alu_rs2_d    = alu_rs2_q;
    alu_opcode_d = alu_opcode_q;
    alu_func3_d  = alu_func3_q;
    alu_func7_d  = alu_func7_q;
    alu_rd_d     = alu_rd_q;
    illegal_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.instr_valid) begin
          instr_d = bus.instr;
          pc_d    = bus.pc;
          state_d = StRead;
        end
      end
      StRead: begin
        if (is_illegal) begin
          // Drop the instruction; the pulse lands in the following IDLE cycle.
          illegal_d = 1'b1;
          state_d   = StIdle;
        end else begin
          alu_rs1_d    = op_rs1;
          alu_rs2_d    = op_rs2;
          alu_opcode_d = opcode;
          alu_func3_d  = op_func3;
          alu_func7_d  = op_func7;
          alu_rd_d     = instr_q[11:7];
          state_d      = StHold;
        end
      end
      StHold: begin
        if (bus.alu_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      instr_q      <= 32'd0;
      pc_q         <= 32'd0;
      alu_rs1_q    <= 32'd0;
      alu_rs2_q    <= 32'd0;
      alu_opcode_q <= 7'd0;
      alu_func3_q  <= 3'd0;
      alu_func7_q  <= 7'd0;
      alu_rd_q     <= 5'd0;
      illegal_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      instr_q      <= instr_d;
      pc_q         <= pc_d;
      alu_rs1_q    <= alu_rs1_d;
      alu_rs2_q    <= alu_rs2_d;
      alu_opcode_q <= alu_opcode_d;
      alu_func3_q  <= alu_func3_d;
      alu_func7_q  <= alu_func7_d;
      alu_rd_q     <= alu_rd_d;
      illegal_q    <= illegal_d;
    end
  end

  assign bus.instr_ready = (state_q == StIdle);
  assign bus.alu_valid   = (state_q == StHold);
  assign bus.rf_rs1_addr = rs1_idx;
  assign bus.rf_rs2_addr = rs2_idx;
  assign bus.alu_rs1     = alu_rs1_q;
  assign bus.alu_rs2     = alu_rs2_q;
  assign bus.alu_opcode  = alu_opcode_q;
  assign bus.alu_func3   = alu_func3_q;
  assign bus.alu_func7   = alu_func7_q;
  assign bus.alu_rd      = alu_rd_q;
  assign bus.illegal     = illegal_q;

endmodule
